// File: rtl/tdc_uart_pkg.sv
// Shared types and helpers for the TDC-to-UART framer.
package tdc_uart_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} framer_state_e;

  localparam int UART_BYTE_W = 8;

  // XOR of the low nbytes bytes of data (up to 8 bytes).
  function automatic logic [UART_BYTE_W-1:0] xor_bytes(input logic [63:0] data,
                                                       input int nbytes);
    logic [UART_BYTE_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbytes) acc = acc ^ data[i*UART_BYTE_W +: UART_BYTE_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/tdc_meas_hold.sv
// One-entry holding register for measurements waiting for the framer.
module tdc_meas_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              meas_valid,
  output logic              meas_ready,
  input  logic [DATA_W-1:0] meas_data,
  input  logic              take,
  output logic              hold_full,
  output logic [DATA_W-1:0] hold_data
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;

  // take is only asserted while full, so load and take never coincide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (meas_valid && !full_q) begin
      full_d = 1'b1;
      data_d = meas_data;
    end else if (take) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign meas_ready = !full_q;
  assign hold_full  = full_q;
  assign hold_data  = data_q;

endmodule

// File: rtl/tdc_uart_framer.sv
// Frames TDC measurements onto a byte stream: SYNC, data bytes MSB first, optional XOR
// checksum when TDC_FRAMER_CHECKSUM_EN is defined.
module tdc_uart_framer
  import tdc_uart_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hAF,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              meas_valid,
  output logic              meas_ready,
  input  logic [DATA_W-1:0] meas_data,
  output logic              axi_valid,
  input  logic              axi_ready,
  output logic [7:0]        axi_data,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam int NBYTES = DATA_W / UART_BYTE_W;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  framer_state_e           state_q, state_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        frames_sent_q, frames_sent_d;
  logic                    hold_full, take, out_hs, frame_end;
  logic [DATA_W-1:0]       hold_data;
  logic [UART_BYTE_W-1:0]  data_byte;

  tdc_meas_hold #(.DATA_W(DATA_W)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_data  (meas_data),
    .take       (take),
    .hold_full  (hold_full),
    .hold_data  (hold_data)
  );

  assign axi_valid   = (state_q != IDLE);
  assign busy        = axi_valid;
  assign out_hs      = axi_valid && axi_ready;
  assign frames_sent = frames_sent_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    idx_d         = idx_q;
    frames_sent_d = frames_sent_q;
    frame_end     = 1'b0;
    case (state_q)
      SYNC: if (out_hs) begin
        state_d = DATA;
        idx_d   = '0;
      end
      DATA: if (out_hs) begin
        if (idx_q == LAST_IDX) begin
`ifdef TDC_FRAMER_CHECKSUM_EN
          state_d = CSUM;
`else
          frame_end = 1'b1;
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`ifdef TDC_FRAMER_CHECKSUM_EN
      CSUM: if (out_hs) frame_end = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
    if (frame_end) begin
      frames_sent_d = frames_sent_q + CNT_W'(1);
      state_d       = IDLE;
      idx_d         = '0;
    end
    // A held measurement starts its frame from IDLE or straight off a frame end.
    take = hold_full && ((state_q == IDLE) || frame_end);
    if (take) begin
      state_d = SYNC;
      shift_d = hold_data;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      idx_q         <= '0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      idx_q         <= idx_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  always_comb begin
    data_byte = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) data_byte = shift_q[DATA_W-1-i*UART_BYTE_W -: UART_BYTE_W];
    end
  end

  always_comb begin
    case (state_q)
      SYNC:    axi_data = SYNC_BYTE;
      DATA:    axi_data = data_byte;
`ifdef TDC_FRAMER_CHECKSUM_EN
      CSUM:    axi_data = xor_bytes(64'(shift_q), NBYTES);
`endif
      default: axi_data = '0;
    endcase
  end

endmodule

// File: tb/tb_tdc_uart_framer.sv
// Randomised and directed bench for tdc_uart_framer with a frame-level scoreboard.
module tb_tdc_uart_framer;

  logic        clk, rst;
  logic        meas_valid, meas_ready;
  logic [31:0] meas_data;
  logic        axi_valid, axi_ready;
  logic [7:0]  axi_data;
  logic        busy;
  logic [15:0] frames_sent;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of expected bytes, frame-end markers and occupancy.
  logic [7:0]  exp_q[$];
  bit          last_q[$];
  int          occ = 0;
  bit          just_acc = 0;
  logic [15:0] frames_exp = 0;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = 0;
  bit          rnd_ready = 0;

  tdc_uart_framer dut (
    .clk         (clk),
    .rst         (rst),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .meas_data   (meas_data),
    .axi_valid   (axi_valid),
    .axi_ready   (axi_ready),
    .axi_data    (axi_data),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] d);
    logic [7:0] x;
    x = 8'h00;
    exp_q.push_back(8'hAF);
    last_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) begin
      logic [7:0] b;
      b = 8'((d >> (8 * i)) & 32'hFF);
      x = x ^ b;
      exp_q.push_back(b);
`ifdef TDC_FRAMER_CHECKSUM_EN
      last_q.push_back(1'b0);
`else
      last_q.push_back(i == 0);
`endif
    end
`ifdef TDC_FRAMER_CHECKSUM_EN
    exp_q.push_back(x);
    last_q.push_back(1'b1);
`endif
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bit on_wire, ready_exp, last;
      logic [7:0] eb;
      on_wire   = (occ > 0) && !just_acc;
      ready_exp = !((occ >= 2) || (occ == 1 && !on_wire));
      check("axi_valid", axi_valid, on_wire);
      check("busy", busy, on_wire);
      check("meas_ready", meas_ready, ready_exp);
      check("frames_sent", frames_sent, frames_exp);
      if (prev_stall) begin
        check("stall_valid", axi_valid, 1);
        check("stall_data", axi_data, prev_data);
      end
      prev_stall = axi_valid && !axi_ready;
      prev_data  = axi_data;
      if (axi_valid && axi_ready) begin
        check("byte_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          eb   = exp_q.pop_front();
          last = last_q.pop_front();
          check("axi_data", axi_data, eb);
          if (last) begin
            frames_exp++;
            occ--;
          end
        end
      end
      just_acc = 0;
      if (meas_valid && ready_exp) begin
        push_frame(meas_data);
        if (occ == 0) just_acc = 1;
        occ++;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) #1 axi_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] d);
    bit hs;
    int n;
    meas_valid = 1;
    meas_data  = d;
    hs = 0;
    n  = 0;
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = meas_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accept", hs, 1);
    $display("send data=0x%08h accepted after %0d cycles", d, n);
    meas_valid = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (occ != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", occ, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    last_q.delete();
    occ = 0;
    just_acc = 0;
    frames_exp = 0;
    prev_stall = 0;
  endtask

  initial begin
    int n34;
    meas_valid = 0;
    meas_data  = 0;
    axi_ready  = 1;
    rst = 1;
    #1 rst = 0;
    #20;
    check("rst_axi_valid", axi_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_meas_ready", meas_ready, 1);
    check("rst_axi_data", axi_data, 0);
    check("rst_frames", frames_sent, 0);
    #6 rst = 1;
    @(posedge clk);
    #1;

    // Single frame.
    send(32'h12345678);
    drain(50);
    check("t1_frames", frames_sent, 1);
    check("t1_busy", busy, 0);

    // Backpressure while 0x34 is presented.
    send(32'h12345678);
    for (int c = 0; c < 20; c++) begin
      if (axi_valid && axi_data == 8'h34) break;
      @(posedge clk);
      #1;
    end
    axi_ready = 0;
    n34 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (axi_valid && axi_data == 8'h34) n34++;
      else break;
      if (n34 == 5) begin
        @(posedge clk);
        #1 axi_ready = 1;
      end
    end
    check("t2_hold_34_cycles", n34, 6);
    drain(50);

    // Back-to-back frames, then a third offered while hold is full.
    send(32'hAAAAAAAA);
    repeat (2) @(posedge clk);
    #1;
    send(32'h55555555);
    drain(50);
    send(32'h01020304);
    send(32'h0A0B0C0D);
    send(32'hF0E0D0C0);
    drain(80);

    // Reset in the middle of the data bytes.
    send(32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1;
    check("t5_axi_valid", axi_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_frames", frames_sent, 0);
    check("t5_axi_data", axi_data, 0);
    check("t5_meas_ready", meas_ready, 1);
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;
    send(32'h0BADF00D);
    drain(50);

    // Counter wrap.
    force dut.frames_sent_q = 16'hFFFF;
    frames_exp = 16'hFFFF;
    @(posedge clk);
    #1 release dut.frames_sent_q;
    send(32'hCAFEF00D);
    drain(50);
    check("t6_wrap", frames_sent, 0);

    // Random traffic with random backpressure.
    rnd_ready = 1;
    for (int k = 0; k < 40; k++) begin
      send($urandom);
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    drain(600);
    rnd_ready = 0;
    #2 axi_ready = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
